// File: rtl/ecc_store_buffer.sv
// rtl/ecc_store_buffer.sv - FIFO store buffer between processor and cache, SEC-DED check bits computed at enqueue.
module ecc_store_buffer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int PARITY_W = 6,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        st_valid_PC,
  output logic                        st_ready_PC,
  input  logic [DATA_W-1:0]           data_PC,
  input  logic [ADDR_W-1:0]           addr_PC,
  input  logic                        special_store_PC,
  input  logic                        flush_PC,
  output logic                        valid_Cache,
  input  logic                        ready_Cache,
  output logic [DATA_W-1:0]           data_Cache,
  output logic [ADDR_W-1:0]           addr_Cache,
  output logic [PARITY_W:0]           parity_Cache,
  output logic                        special_store_Cache,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Data bits fill the non-power-of-two codeword positions in ascending order.
  function automatic logic [PARITY_W:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [PARITY_W-1:0] chk;
    int k;
    chk = '0;
    k   = 0;
    for (int pos = 1; pos <= DATA_W + PARITY_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (k < DATA_W) begin
          for (int i = 0; i < PARITY_W; i++) begin
            if (pos[i]) chk[i] = chk[i] ^ d[k];
          end
        end
        k++;
      end
    end
    return {(^d) ^ (^chk), chk};
  endfunction

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];
  logic [PARITY_W:0]   par_mem  [DEPTH];
  logic                spec_mem [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop;
  logic                not_empty;
  logic [PARITY_W:0]   enc_par;

  assign not_empty   = (count_q != '0);
  assign st_ready_PC = (count_q != CNT_W'(DEPTH));
  assign valid_Cache = not_empty;
  assign count       = count_q;

  assign push    = st_valid_PC && st_ready_PC && !flush_PC;
  assign pop     = not_empty && ready_Cache && !flush_PC;
  assign enc_par = ecc_encode(data_PC);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_PC) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; empty-buffer outputs are masked instead.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr_q] <= data_PC;
      addr_mem[wr_ptr_q] <= addr_PC;
      par_mem[wr_ptr_q]  <= enc_par;
      spec_mem[wr_ptr_q] <= special_store_PC;
    end
  end

  always_comb begin
    data_Cache          = '0;
    addr_Cache          = '0;
    parity_Cache        = '0;
    special_store_Cache = 1'b0;
    if (not_empty) begin
      data_Cache          = data_mem[rd_ptr_q];
      addr_Cache          = addr_mem[rd_ptr_q];
      parity_Cache        = par_mem[rd_ptr_q];
      special_store_Cache = spec_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_ecc_store_buffer.sv
// tb/tb_ecc_store_buffer.sv - directed self-checking bench for ecc_store_buffer.
module tb_ecc_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid_PC;
  logic        st_ready_PC;
  logic [31:0] data_PC;
  logic [31:0] addr_PC;
  logic        special_store_PC;
  logic        flush_PC;
  logic        valid_Cache;
  logic        ready_Cache;
  logic [31:0] data_Cache;
  logic [31:0] addr_Cache;
  logic [6:0]  parity_Cache;
  logic        special_store_Cache;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ecc_store_buffer #(.DATA_W(32), .ADDR_W(32), .PARITY_W(6), .DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .st_valid_PC         (st_valid_PC),
    .st_ready_PC         (st_ready_PC),
    .data_PC             (data_PC),
    .addr_PC             (addr_PC),
    .special_store_PC    (special_store_PC),
    .flush_PC            (flush_PC),
    .valid_Cache         (valid_Cache),
    .ready_Cache         (ready_Cache),
    .data_Cache          (data_Cache),
    .addr_Cache          (addr_Cache),
    .parity_Cache        (parity_Cache),
    .special_store_Cache (special_store_Cache),
    .count               (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [31:0] d, input logic [31:0] a, input logic s);
    st_valid_PC      = 1'b1;
    data_PC          = d;
    addr_PC          = a;
    special_store_PC = s;
    step();
    st_valid_PC      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid_PC = 1'b0; data_PC = '0; addr_PC = '0;
    special_store_PC = 1'b0; flush_PC = 1'b0; ready_Cache = 1'b0;
    step(); step();
    reset = 1'b0;

    check("rst_count", count, 0);
    check("rst_ready", st_ready_PC, 1);
    check("rst_valid", valid_Cache, 0);
    check("rst_data", data_Cache, 0);
    check("rst_parity", parity_Cache, 0);

    // zero data: one-cycle latency, all-zero check bits
    push_store(32'h0000_0000, 32'h100, 1'b0);
    check("lat_valid", valid_Cache, 1);
    check("zero_parity", parity_Cache, 7'h00);
    check("zero_count", count, 1);
    check("zero_addr", addr_Cache, 32'h100);
    ready_Cache = 1'b1; step(); ready_Cache = 1'b0;
    check("zero_drained", count, 0);

    // single-bit encodings
    push_store(32'h0000_0001, 32'h104, 1'b0);
    push_store(32'h0000_0002, 32'h108, 1'b0);
    push_store(32'h8000_0000, 32'h10C, 1'b1);
    check("bit0_data", data_Cache, 32'h1);
    check("bit0_parity", parity_Cache, 7'h43);
    ready_Cache = 1'b1; step();
    check("bit1_data", data_Cache, 32'h2);
    check("bit1_parity", parity_Cache, 7'h45);
    step();
    check("bit31_parity", parity_Cache, 7'h26);
    check("bit31_special", special_store_Cache, 1);
    check("bit31_addr", addr_Cache, 32'h10C);
    step(); ready_Cache = 1'b0;
    check("bits_empty", count, 0);
    check("empty_special", special_store_Cache, 0);

    // fill to DEPTH, fifth push ignored, drain in order
    for (int i = 0; i < 4; i++) push_store(32'hA000_0000 + i, 32'h200 + 4 * i, 1'b0);
    check("full_count", count, 4);
    check("full_ready", st_ready_PC, 0);
    push_store(32'hDEAD_BEEF, 32'h2FF, 1'b1);
    check("full_ignored", count, 4);
    ready_Cache = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", data_Cache, 32'hA000_0000 + i);
      check("drain_addr", addr_Cache, 32'h200 + 4 * i);
      step();
    end
    ready_Cache = 1'b0;
    check("drain_count", count, 0);
    check("drain_valid", valid_Cache, 0);
    check("drain_data0", data_Cache, 0);

    // concurrent push/pop at count=2 across pointer wrap
    push_store(32'd100, 32'h300, 1'b0);
    push_store(32'd101, 32'h304, 1'b0);
    ready_Cache = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      st_valid_PC = 1'b1; data_PC = 32'd101 + k; addr_PC = 32'h300 + 4 * (k + 1);
      step();
      check("pp_count", count, 2);
      check("pp_head", data_Cache, 32'd100 + k);
    end
    st_valid_PC = 1'b0;
    step(); step();
    ready_Cache = 1'b0;
    check("pp_drained", count, 0);

    // flush overrides push and pop
    for (int i = 0; i < 3; i++) push_store(32'hF000_0000 + i, 32'h400, 1'b0);
    check("pre_flush_count", count, 3);
    flush_PC = 1'b1; st_valid_PC = 1'b1; ready_Cache = 1'b1; data_PC = 32'h1234_5678;
    step();
    flush_PC = 1'b0; st_valid_PC = 1'b0; ready_Cache = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", valid_Cache, 0);
    check("flush_data", data_Cache, 0);
    check("flush_parity", parity_Cache, 0);
    check("flush_ready", st_ready_PC, 1);

    // reset overrides a pending push
    for (int i = 0; i < 3; i++) push_store(32'hE000_0000 + i, 32'h500, 1'b1);
    check("pre_rst_count", count, 3);
    reset = 1'b1; st_valid_PC = 1'b1;
    step();
    reset = 1'b0; st_valid_PC = 1'b0;
    check("rst2_count", count, 0);
    check("rst2_ready", st_ready_PC, 1);
    check("rst2_valid", valid_Cache, 0);
    check("rst2_addr", addr_Cache, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecc_store_buffer.md
ECC_STORE_BUFFER -- requirements
Module: ecc_store_buffer

Interface
REQ-001 Parameter DATA_W, default 32, store data width.
REQ-002 Parameter ADDR_W, default 32, store address width.
REQ-003 Parameter PARITY_W, default 6, Hamming check bits; smallest r with 2^r >= DATA_W + r + 1.
REQ-004 Parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-005 One clock; reset is synchronous and active-high; ports are clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 st_valid_PC  input  1  processor store request.
REQ-009 st_ready_PC  output  1  buffer can accept a store.
REQ-010 data_PC  input  DATA_W  store data.
REQ-011 addr_PC  input  ADDR_W  store address.
REQ-012 special_store_PC  input  1  special-store flag.
REQ-013 flush_PC  input  1  discard all buffered stores.
REQ-014 valid_Cache  output  1  head entry presented to cache.
REQ-015 ready_Cache  input  1  cache accepts head entry.
REQ-016 data_Cache  output  DATA_W  head data.
REQ-017 addr_Cache  output  ADDR_W  head address.
REQ-018 parity_Cache  output  PARITY_W+1  [PARITY_W-1:0] Hamming check bits, [PARITY_W] DED bit.
REQ-019 special_store_Cache  output  1  head special-store flag.
REQ-020 count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-021 Check bits SHALL be computed at enqueue and stored per entry, never recomputed at dequeue.
REQ-022 Encoding: data bits occupy 1-based codeword positions that are not powers of two, ascending (data bit 0 at position 3); check bit i SHALL be XOR of data bits whose position has bit i set.
REQ-023 DED bit SHALL be XOR of all DATA_W data bits and all PARITY_W check bits.
REQ-024 Push SHALL occur on a clk edge with st_valid_PC && st_ready_PC && !flush_PC.
REQ-025 Pop SHALL occur on a clk edge with valid_Cache && ready_Cache && !flush_PC.
REQ-026 st_ready_PC SHALL equal (count != DEPTH); no combinational path from ready_Cache.
REQ-027 valid_Cache SHALL equal (count != 0).
REQ-028 Entries SHALL leave in push order (FIFO); head fields drive data_Cache, addr_Cache, parity_Cache, special_store_Cache.
REQ-029 When count == 0, data/addr/parity/special outputs SHALL be driven to 0.
REQ-030 Simultaneous push and pop SHALL leave count unchanged, both pointers advancing.
REQ-031 Push with count == DEPTH is impossible (st_ready_PC low); st_valid_PC SHALL be ignored.
REQ-032 Pop with count == 0 is impossible; ready_Cache SHALL be ignored.
REQ-033 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-034 Latency: a store pushed at edge N SHALL appear at the cache interface after edge N if buffer was empty (one cycle).
REQ-035 flush_PC high at an edge SHALL set count, pointers to 0, overriding any push or pop that cycle.
REQ-036 Stored payload SHALL not change while an entry is buffered, regardless of PC inputs.

Reset
REQ-037 reset high at an edge SHALL set count=0, pointers=0; valid_Cache=0, st_ready_PC=1, all cache data outputs 0 from the next cycle.
REQ-038 reset SHALL override flush, push and pop; entries in flight mid-operation are discarded.
REQ-039 Entry storage need not be reset; outputs SHALL be masked by REQ-029.

Verification
REQ-040 Push data 0x00000000, addr 0x100, special 0 into empty buffer -> next cycle valid_Cache=1, parity_Cache=7'h00, count=1.
REQ-041 Push data 0x00000001 -> parity_Cache=7'h43 (check bits 6'b000011, DED 1); data 0x00000002 -> 7'h45.
REQ-042 Hold ready_Cache=0, push 4 stores (DEPTH=4) -> count=4, st_ready_PC=0, fifth push ignored; release ready -> four entries drained in order.
REQ-043 count=2, push and pop same edge -> count stays 2, head advances; repeat 10 times to exercise pointer wrap.
REQ-044 count=3, flush_PC with st_valid_PC=1 and ready_Cache=1 -> count=0, valid_Cache=0, outputs 0 next cycle.
REQ-045 Reset asserted with count=3 and push pending -> count=0, st_ready_PC=1, valid_Cache=0 next cycle.
